mem_arbiter: RTL and testbench

- Parametrised successor to the fixed 4-slot memory multiplexer.
- Shares one synchronous single-port RAM among NPORTS requesters (HERA core, SPI debug port, future peripherals).
- Arbitration is request-driven, not a free-running time slot: round-robin or fixed priority, one access per cycle.
- Each requester gets grant/response handshakes, bounds checking and held read data.

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Request-driven arbiter sharing one synchronous single-port RAM among NPORTS requesters.
// Round-robin or fixed-priority grant, registered completion pulses, per-port held read data.
module mem_arbiter #(
  parameter int unsigned NPORTS    = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 8192,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] wdata,
  output logic [NPORTS-1:0]        gnt,
  output logic [NPORTS-1:0]        rvalid,
  output logic [NPORTS*DATA_W-1:0] rdata,
  output logic [NPORTS-1:0]        err,
  output logic                     busy
);

  localparam int unsigned PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DATA_W-1:0]        ram_q;

  logic [PW-1:0]            last;
  logic [PW-1:0]            sel;
  logic                     sel_vld;
  logic [NPORTS-1:0]        gnt_c;

  logic                     sel_we;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_wdata;
  logic                     in_range;
  logic                     access;
  logic [RAM_AW-1:0]        ram_idx;

  logic [NPORTS-1:0]        rvalid_q;
  logic [NPORTS-1:0]        err_q;
  logic [NPORTS-1:0]        rd_pend;
  logic                     rd_zero;
  logic [NPORTS*DATA_W-1:0] rdata_hold;
  logic [NPORTS*DATA_W-1:0] rdata_c;

  // Winner search: round-robin starts just after the last granted port, fixed priority from port 0.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (FIXED_PRI != 0) begin
        idx = k;
      end else begin
        idx = (32'(last) + k + 1) % NPORTS;
      end
      if (!sel_vld && req[idx[PW-1:0]]) begin
        sel     = idx[PW-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_c = '0;
    if (rst && sel_vld) begin
      gnt_c[sel] = 1'b1;
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (gnt_c[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign access   = |gnt_c;
  assign in_range = ({1'b0, sel_addr} < DEPTH_EXT);
  assign ram_idx  = sel_addr[RAM_AW-1:0];

  always_ff @(posedge clk) begin
    if (access && sel_we && in_range) begin
      mem[ram_idx] <= sel_wdata;
    end
    if (access && !sel_we) begin
      ram_q <= mem[ram_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_q <= '0;
      err_q    <= '0;
      rd_pend  <= '0;
      rd_zero  <= 1'b0;
      last     <= PW'(NPORTS - 1);
    end else begin
      rvalid_q <= gnt_c;
      err_q    <= in_range ? '0 : gnt_c;
      rd_pend  <= sel_we ? '0 : gnt_c;
      rd_zero  <= !in_range;
      if (access) begin
        last <= sel;
      end
    end
  end

  // The single RAM output register is steered into the completing lane for one cycle;
  // the lane holding register then captures it so data stays valid until the next read.
  always_comb begin
    rdata_c = rdata_hold;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (rd_pend[i]) begin
        rdata_c[i*DATA_W +: DATA_W] = rd_zero ? '0 : ram_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_hold <= '0;
    end else begin
      rdata_hold <= rdata_c;
    end
  end

  assign gnt    = gnt_c;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rdata_c;
  assign busy   = |req;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a queue-free arithmetic reference model (grant order, sparse memory, held lanes).
module tb_mem_arbiter;

  localparam int NP    = 4;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 8192;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req;
  logic [NP-1:0]    we;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;

  logic [NP-1:0]    gnt, rvalid, err;
  logic [NP*DW-1:0] rdata;
  logic             busy;
  logic [NP-1:0]    gnt_fp, rvalid_fp, err_fp;
  logic [NP*DW-1:0] rdata_fp;
  logic             busy_fp;

  int total = 0;
  int bad   = 0;

  int           m_last;
  logic [DW-1:0] m_mem [int];
  logic [DW-1:0] m_rdata [NP];

  always #5 clk = ~clk;

  mem_arbiter #(.NPORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FIXED_PRI(0)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err), .busy(busy)
  );

  mem_arbiter #(.NPORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_fp), .rvalid(rvalid_fp), .rdata(rdata_fp), .err(err_fp), .busy(busy_fp)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle;
    req = '0;
    we  = '0;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p] = r;
    we[p]  = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] lane(input int p);
    return rdata[p*DW +: DW];
  endfunction

  task automatic apply_reset;
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst    = 1'b1;
    m_last = NP - 1;
    for (int i = 0; i < NP; i++) m_rdata[i] = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req = '1;
    we  = '0;
    tick();
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
    total++; if (gnt_fp !== 4'b0000) begin bad++; $display("FAIL reset_gnt_fp got=%b exp=%b", gnt_fp, 4'b0000); end
    total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL reset_rvalid got=%b exp=%b", rvalid, 4'b0000); end
    total++; if (err !== 4'b0000) begin bad++; $display("FAIL reset_err got=%b exp=%b", err, 4'b0000); end
    total++; if (rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 64'h0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy_hi got=%b exp=1", busy); end
    idle();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_lo got=%b exp=0", busy); end
    rst    = 1'b1;
    m_last = NP - 1;
    for (int i = 0; i < NP; i++) m_rdata[i] = '0;
  endtask

  task automatic test_write_read;
    apply_reset();
    set_port(1, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    #1;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL wr_gnt got=%b exp=%b", gnt, 4'b0010); end
    tick();
    total++; if (rvalid !== 4'b0010) begin bad++; $display("FAIL wr_rvalid got=%b exp=%b", rvalid, 4'b0010); end
    total++; if (err !== 4'b0000) begin bad++; $display("FAIL wr_err got=%b exp=%b", err, 4'b0000); end
    idle();
    set_port(3, 1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL rd_gnt got=%b exp=%b", gnt, 4'b1000); end
    tick();
    total++; if (rvalid !== 4'b1000) begin bad++; $display("FAIL rd_rvalid got=%b exp=%b", rvalid, 4'b1000); end
    total++; if (err !== 4'b0000) begin bad++; $display("FAIL rd_err got=%b exp=%b", err, 4'b0000); end
    total++; if (lane(3) !== 16'hBEEF) begin bad++; $display("FAIL rd_lane3 got=%h exp=%h", lane(3), 16'hBEEF); end
    idle();
    tick();
    total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL rd_pulse_end got=%b exp=%b", rvalid, 4'b0000); end
  endtask

  task automatic test_round_robin;
    int cnt [NP];
    logic [NP-1:0] exp_g;
    apply_reset();
    for (int i = 0; i < NP; i++) begin
      cnt[i] = 0;
      set_port(i, 1'b1, 1'b0, 16'h0010, 16'h0000);
    end
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_g = '0;
      exp_g[c % NP] = 1'b1;
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_g); end
      tick();
      total++; if (rvalid !== exp_g) begin bad++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=%b", c, rvalid, exp_g); end
      for (int i = 0; i < NP; i++) if (rvalid[i] === 1'b1) cnt[i]++;
    end
    idle();
    for (int i = 0; i < NP; i++) begin
      total++; if (cnt[i] != 2) begin bad++; $display("FAIL rr_count port=%0d got=%0d exp=2", i, cnt[i]); end
      total++; if (lane(i) !== 16'hBEEF) begin bad++; $display("FAIL rr_lane port=%0d got=%h exp=%h", i, lane(i), 16'hBEEF); end
    end
  endtask

  task automatic test_fixed_priority;
    logic [NP-1:0] exp_g;
    apply_reset();
    for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b0, 16'h0010, 16'h0000);
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (gnt_fp !== 4'b0001) begin bad++; $display("FAIL fp_gnt cyc=%0d got=%b exp=%b", c, gnt_fp, 4'b0001); end
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      req = NP'($urandom_range(0, (1 << NP) - 1));
      #1;
      exp_g = '0;
      for (int i = NP - 1; i >= 0; i--) if (req[i]) begin exp_g = '0; exp_g[i] = 1'b1; end
      total++; if (gnt_fp !== exp_g) begin bad++; $display("FAIL fp_rnd_gnt req=%b got=%b exp=%b", req, gnt_fp, exp_g); end
      tick();
    end
    idle();
  endtask

  task automatic test_out_of_range;
    apply_reset();
    set_port(2, 1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();
    total++; if (lane(2) !== 16'hBEEF) begin bad++; $display("FAIL oor_pre_lane2 got=%h exp=%h", lane(2), 16'hBEEF); end
    idle();
    set_port(0, 1'b1, 1'b1, 16'h0000, 16'hA5A5);
    tick();
    idle();
    set_port(2, 1'b1, 1'b0, 16'h2000, 16'h0000);
    #1;
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL oor_rd_gnt got=%b exp=%b", gnt, 4'b0100); end
    tick();
    total++; if (rvalid !== 4'b0100) begin bad++; $display("FAIL oor_rd_rvalid got=%b exp=%b", rvalid, 4'b0100); end
    total++; if (err !== 4'b0100) begin bad++; $display("FAIL oor_rd_err got=%b exp=%b", err, 4'b0100); end
    total++; if (lane(2) !== 16'h0000) begin bad++; $display("FAIL oor_rd_lane2 got=%h exp=%h", lane(2), 16'h0000); end
    idle();
    tick();
    total++; if (err !== 4'b0000) begin bad++; $display("FAIL oor_err_pulse got=%b exp=%b", err, 4'b0000); end
    set_port(2, 1'b1, 1'b1, 16'h2000, 16'h1234);
    tick();
    total++; if (err !== 4'b0100) begin bad++; $display("FAIL oor_wr_err got=%b exp=%b", err, 4'b0100); end
    total++; if (rvalid !== 4'b0100) begin bad++; $display("FAIL oor_wr_rvalid got=%b exp=%b", rvalid, 4'b0100); end
    set_port(2, 1'b1, 1'b0, 16'h0000, 16'h0000);
    tick();
    total++; if (err !== 4'b0000) begin bad++; $display("FAIL oor_alias_err got=%b exp=%b", err, 4'b0000); end
    total++; if (lane(2) !== 16'hA5A5) begin bad++; $display("FAIL oor_alias_lane2 got=%h exp=%h", lane(2), 16'hA5A5); end
    set_port(2, 1'b1, 1'b0, 16'hFFFF, 16'h0000);
    tick();
    total++; if (err !== 4'b0100) begin bad++; $display("FAIL oor_top_err got=%b exp=%b", err, 4'b0100); end
    idle();
  endtask

  task automatic test_reset_mid_op;
    apply_reset();
    set_port(0, 1'b1, 1'b1, 16'h0020, 16'h1111);
    tick();
    set_port(0, 1'b1, 1'b1, 16'h0020, 16'h2222);
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rmid_wr_gnt got=%b exp=%b", gnt, 4'b0001); end
    rst = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rmid_gnt_forced got=%b exp=%b", gnt, 4'b0000); end
    tick();
    total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL rmid_wr_rvalid got=%b exp=%b", rvalid, 4'b0000); end
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rmid_rd_gnt got=%b exp=%b", gnt, 4'b0001); end
    rst = 1'b0;
    tick();
    total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL rmid_rd_rvalid got=%b exp=%b", rvalid, 4'b0000); end
    total++; if (err !== 4'b0000) begin bad++; $display("FAIL rmid_rd_err got=%b exp=%b", err, 4'b0000); end
    total++; if (lane(0) !== 16'h0000) begin bad++; $display("FAIL rmid_lane0 got=%h exp=%h", lane(0), 16'h0000); end
    idle();
    tick();
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    set_port(3, 1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rmid_first_gnt got=%b exp=%b", gnt, 4'b0001); end
    tick();
    total++; if (lane(0) !== 16'h1111) begin bad++; $display("FAIL rmid_wr_dropped got=%h exp=%h", lane(0), 16'h1111); end
    req[0] = 1'b0;
    #1;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL rmid_second_gnt got=%b exp=%b", gnt, 4'b1000); end
    tick();
    total++; if (lane(3) !== 16'hBEEF) begin bad++; $display("FAIL rmid_lane3 got=%h exp=%h", lane(3), 16'hBEEF); end
    idle();
  endtask

  task automatic test_hold_lanes;
    apply_reset();
    set_port(2, 1'b1, 1'b1, 16'h0005, 16'h5A5A);
    tick();
    idle();
    set_port(1, 1'b1, 1'b0, 16'h0005, 16'h0000);
    tick();
    total++; if (lane(1) !== 16'h5A5A) begin bad++; $display("FAIL hold_rd_lane1 got=%h exp=%h", lane(1), 16'h5A5A); end
    set_port(1, 1'b1, 1'b1, 16'h0005, 16'h7777);
    #1;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL hold_b2b_gnt got=%b exp=%b", gnt, 4'b0010); end
    tick();
    total++; if (rvalid !== 4'b0010) begin bad++; $display("FAIL hold_wr_rvalid got=%b exp=%b", rvalid, 4'b0010); end
    total++; if (lane(1) !== 16'h5A5A) begin bad++; $display("FAIL hold_wr_lane1 got=%h exp=%h", lane(1), 16'h5A5A); end
    idle();
    set_port(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();
    total++; if (lane(0) !== 16'hBEEF) begin bad++; $display("FAIL hold_lane0 got=%h exp=%h", lane(0), 16'hBEEF); end
    total++; if (lane(1) !== 16'h5A5A) begin bad++; $display("FAIL hold_other_lane1 got=%h exp=%h", lane(1), 16'h5A5A); end
    idle();
    set_port(1, 1'b1, 1'b0, 16'h0005, 16'h0000);
    tick();
    total++; if (lane(1) !== 16'h7777) begin bad++; $display("FAIL hold_raw_lane1 got=%h exp=%h", lane(1), 16'h7777); end
    idle();
  endtask

  task automatic gen_txn(input int p);
    int unsigned kind;
    logic [AW-1:0] a;
    kind = $urandom_range(0, 9);
    a    = AW'(16'h0100 + $urandom_range(0, 15));
    if (kind < 2) begin
      set_port(p, 1'b0, 1'b0, '0, '0);
    end else if (kind == 2) begin
      set_port(p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(DEPTH, 16'hFFFF)), DW'($urandom));
    end else if (kind <= 6 || !m_mem.exists(int'(a))) begin
      set_port(p, 1'b1, 1'b1, a, DW'($urandom));
    end else begin
      set_port(p, 1'b1, 1'b0, a, '0);
    end
  endtask

  task automatic test_random;
    int g;
    int a;
    logic [NP-1:0] exp_g, exp_fp, exp_err;
    apply_reset();
    m_mem.delete();
    for (int i = 0; i < NP; i++) gen_txn(i);
    for (int c = 0; c < 400; c++) begin
      #1;
      g = -1;
      for (int k = 1; k <= NP; k++) if (g < 0 && req[(m_last + k) % NP]) g = (m_last + k) % NP;
      exp_g = '0;
      if (g >= 0) exp_g[g] = 1'b1;
      exp_fp = '0;
      for (int i = NP - 1; i >= 0; i--) if (req[i]) begin exp_fp = '0; exp_fp[i] = 1'b1; end
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_g); end
      total++; if (gnt_fp !== exp_fp) begin bad++; $display("FAIL rnd_gnt_fp cyc=%0d got=%b exp=%b", c, gnt_fp, exp_fp); end
      total++; if (busy !== (req != 0)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, (req != 0)); end
      exp_err = '0;
      if (g >= 0) begin
        a = int'(addr[g*AW +: AW]);
        if (a >= DEPTH) exp_err = exp_g;
        if (!we[g]) m_rdata[g] = (a < DEPTH) ? m_mem[a] : '0;
        else if (a < DEPTH) m_mem[a] = wdata[g*DW +: DW];
        m_last = g;
      end
      tick();
      total++; if (rvalid !== exp_g) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, rvalid, exp_g); end
      total++; if (err !== exp_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err, exp_err); end
      for (int i = 0; i < NP; i++) begin
        total++;
        if (lane(i) !== m_rdata[i]) begin
          bad++; $display("FAIL rnd_rdata cyc=%0d lane=%0d got=%h exp=%h", c, i, lane(i), m_rdata[i]);
        end
      end
      if (g >= 0) gen_txn(g);
      for (int i = 0; i < NP; i++) if (i != g && !req[i] && $urandom_range(0, 2) == 0) gen_txn(i);
    end
    idle();
  endtask

  initial begin
    rst   = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_priority();
    test_out_of_range();
    test_reset_mid_op();
    test_hold_lanes();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

endmodule
